// File: rtl/fifo_resp_pkg.sv
// Shared constants and helpers for the fifo_responder slice.
// Optional stall injection is enabled by defining FIFO_RESP_STALL_EN.
package fifo_resp_pkg;

    // Fibonacci LFSR feedback taps 16,14,13,11 (bit positions 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_resp_lfsr.sv
// 16-bit Fibonacci LFSR used as the stall source of fifo_responder.
// Only instantiated when FIFO_RESP_STALL_EN is defined.
module fifo_resp_lfsr
    import fifo_resp_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift left, feeding back the XOR of the tapped bits.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // State register, reloaded with the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/fifo_responder.sv
// Responding end of the push/pop FIFO protocol: flop-array FIFO with
// first-word-fall-through read data, occupancy and sticky error flags.
// Defining FIFO_RESP_STALL_EN adds LFSR-driven random stalls that mask
// both directions for a cycle.
module fifo_responder
    import fifo_resp_pkg::*;
#(
    parameter type         dtype      = logic [7:0],
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned STALL_RATE = 4,
    parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  dtype                          wdata,
    output logic                          full,
    input  logic                          pop,
    output dtype                          rdata,
    output logic                          empty,
    output logic [ptr_width(DEPTH)-1:0]   usage,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = PW - 1;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    dtype mem_q [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic stall;

    logic full_int;
    logic empty_int;
    logic push_ok;
    logic pop_ok;
    ptr_t level;

`ifdef FIFO_RESP_STALL_EN
    localparam logic [4:0] STALL_THR = 5'(STALL_RATE);

    logic [15:0] lfsr;
    logic        stall_q;
    logic        unused_lfsr_hi;

    fifo_resp_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .out (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:4];

    // Registered stall decision from the low LFSR nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= ({1'b0, lfsr[3:0]} < STALL_THR);
        end
    end

    assign stall = stall_q;
`else
    logic unused_stall_cfg;

    assign unused_stall_cfg = ^{LFSR_SEED, 5'(STALL_RATE)};
    assign stall            = 1'b0;
`endif

    assign level     = wr_ptr_q - rd_ptr_q;
    assign full_int  = (level == DEPTH_P);
    assign empty_int = (level == '0);

    assign full      = full_int | stall;
    assign empty     = empty_int | stall;
    assign usage     = level;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign rdata     = empty_int ? dtype'('0) : mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next pointers and sticky flags; flush discards any same-cycle request.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            // Flags track the real occupancy, so stall-only rejections never set them.
            if (push && full_int) begin
                ovf_d = 1'b1;
            end
            if (pop && empty_int) begin
                unf_d = 1'b1;
            end
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage write on an accepted push; contents are never cleared.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule
